// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl_pkg: state encodings, mode codes and mode decoding shared by the scan controller, board top and bench
package mux_scan_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10,
        ST_STEP   = 2'b11
    } state_e;
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;
    // The reserved mode code falls back to MANUAL.
    function automatic state_e mode_to_state(input logic [1:0] m);
        return m == MODE_AUTO ? ST_AUTO : m == MODE_STEP ? ST_STEP : ST_MANUAL;
    endfunction
endpackage

// File: rtl/mux_scan_ctrl_rate_divider.sv
// rate_divider: down-counter from DIV_MAX that flags zero; load restarts the period
module rate_divider #(
    parameter int          DIV_WIDTH = 26,
    parameter int unsigned DIV_MAX   = 49999999
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic zero
);
    localparam logic [DIV_WIDTH-1:0] MAX = DIV_WIDTH'(DIV_MAX);
    if (64'(DIV_MAX) >= (64'd1 << DIV_WIDTH)) begin : g_div_max_chk
        $error("rate_divider: DIV_MAX does not fit in DIV_WIDTH bits");
    end
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? MAX : cnt_q - DIV_WIDTH'(1);
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= MAX;
        else cnt_q <= cnt_d;
    end
    assign zero = cnt_q == '0;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: 4:1 mux select sequencer with manual, timed auto-scan and single-step modes
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int          DIV_WIDTH = 26,
    parameter int unsigned DIV_MAX   = 49999999
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [1:0] manual_sel,
    input  logic       step,
    output logic [1:0] sel,
    output logic       tick,
    output logic       wrap,
    output logic [1:0] state
);
    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       tick_q, tick_d, wrap_q, wrap_d, step_q;
    logic       zero, load, stay, adv;
    rate_divider #(.DIV_WIDTH(DIV_WIDTH), .DIV_MAX(DIV_MAX)) u_div (
        .clock(clock),
        .reset(reset),
        .load (load),
        .zero (zero)
    );
    // Advances only happen while remaining in AUTO/STEP; any transition restarts the period.
    always_comb begin
        state_d = enable ? mode_to_state(mode) : ST_IDLE;
        stay    = state_d == state_q;
        adv     = stay && ((state_q == ST_AUTO && zero) || (state_q == ST_STEP && step && !step_q));
        load    = !stay || state_d != ST_AUTO || zero;
        sel_d   = state_d == ST_MANUAL ? manual_sel : sel_q + 2'(adv);
        tick_d  = adv;
        wrap_d  = adv && sel_q == 2'd3;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            step_q  <= step;
        end
    end
    assign sel   = sel_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;
    assign state = state_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench; tests queue expected tick events, a monitor pops them as ticks appear
module tb_mux_scan_ctrl;
    import mux_scan_ctrl_pkg::*;
    localparam int          DW = 4;
    localparam int unsigned DM = 3;
    localparam int          P  = DM + 1;

    logic       clock = 0, reset = 1, enable = 0, step = 0;
    logic [1:0] mode = MODE_MANUAL, manual_sel = 2'b00;
    logic [1:0] sel, state;
    logic       tick, wrap;

    always #5 clock = ~clock;

    mux_scan_ctrl #(.DIV_WIDTH(DW), .DIV_MAX(DM)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .manual_sel(manual_sel),
        .step      (step),
        .sel       (sel),
        .tick      (tick),
        .wrap      (wrap),
        .state     (state)
    );

    typedef struct {
        logic [1:0] sel;
        logic       wrap;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    bit   mon_en = 0;

    always @(posedge clock) begin
        exp_t e;
        cyc++;
        #1;
        if (mon_en) begin
            vectors++;
            if (wrap === 1'b1 && tick !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_without_tick cyc=%0d got wrap=%b tick=%b, want wrap=0", cyc, wrap, tick);
            end
            if (tick === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_tick cyc=%0d got sel=%0d wrap=%b, want no tick", cyc, sel, wrap);
                end else begin
                    e = sb.pop_front();
                    if (sel !== e.sel || wrap !== e.wrap || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL tick_event got sel=%0d wrap=%b cyc=%0d, want sel=%0d wrap=%b cyc=%0d",
                                 sel, wrap, cyc, e.sel, e.wrap, e.cyc);
                    end
                end
            end
        end
    end

    task automatic clk(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic push(input logic [1:0] s, input logic w, input int c);
        exp_t e;
        e.sel  = s;
        e.wrap = w;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic enter_auto(input logic [1:0] s0, output int c);
        enable     = 1;
        mode       = MODE_MANUAL;
        manual_sel = s0;
        clk(1);
        mode = MODE_AUTO;
        c    = cyc;
    endtask

    task automatic test_reset();
        reset = 1;
        clk(2);
        vectors++;
        if ({state, sel, tick, wrap} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset got state=%b sel=%b tick=%b wrap=%b, want all 0", state, sel, tick, wrap);
        end
        reset  = 0;
        mon_en = 1;
    endtask

    task automatic test_auto();
        int c;
        enable = 1;
        mode   = MODE_AUTO;
        c      = cyc;
        for (int k = 1; k <= 5; k++) push(2'(k % 4), (k % 4) == 0, c + 1 + k * P);
        clk(1 + 5 * P);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL auto_ticks got %0d pending, want 0", sb.size());
        end
        sb.delete();
        vectors++;
        if (state !== ST_AUTO || sel !== 2'd1) begin
            miscompares++;
            $display("FAIL auto_end got state=%b sel=%0d, want state=%b sel=1", state, sel, ST_AUTO);
        end
    endtask

    task automatic test_manual();
        mode       = MODE_MANUAL;
        manual_sel = 2'b10;
        vectors++;
        if (sel !== 2'd1) begin
            miscompares++;
            $display("FAIL manual_latency got sel=%0d before edge, want 1", sel);
        end
        clk(1);
        vectors++;
        if (sel !== 2'b10 || tick !== 1'b0 || wrap !== 1'b0 || state !== ST_MANUAL) begin
            miscompares++;
            $display("FAIL manual_load got sel=%b tick=%b wrap=%b state=%b, want sel=10 tick=0 wrap=0 state=01",
                     sel, tick, wrap, state);
        end
        mode       = MODE_RSVD;
        manual_sel = 2'b01;
        clk(1);
        vectors++;
        if (sel !== 2'b01 || state !== ST_MANUAL) begin
            miscompares++;
            $display("FAIL mode11_manual got sel=%b state=%b, want sel=01 state=01", sel, state);
        end
        clk(6);
        vectors++;
        if (sel !== 2'b01 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL manual_hold got sel=%b tick=%b, want sel=01 tick=0", sel, tick);
        end
    endtask

    task automatic test_step();
        logic [1:0] exp_sel;
        mode = MODE_STEP;
        step = 0;
        clk(1);
        vectors++;
        if (state !== ST_STEP || sel !== 2'd1) begin
            miscompares++;
            $display("FAIL step_entry got state=%b sel=%0d, want state=11 sel=1", state, sel);
        end
        exp_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            exp_sel = exp_sel + 2'd1;
            step    = 1;
            push(exp_sel, exp_sel == 2'd0, cyc + 1);
            clk(5);
            vectors++;
            if (sel !== exp_sel) begin
                miscompares++;
                $display("FAIL step_once pulse=%0d got sel=%0d, want %0d", k, sel, exp_sel);
            end
            step = 0;
            clk(2);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL step_ticks got %0d pending, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_enable_drop();
        int c, d;
        enter_auto(2'b00, c);
        push(2'd1, 1'b0, c + 1 + P);
        clk(P + 2);
        enable = 0;
        clk(1);
        vectors++;
        if (state !== ST_IDLE || sel !== 2'd1) begin
            miscompares++;
            $display("FAIL drop_idle got state=%b sel=%0d, want state=00 sel=1", state, sel);
        end
        clk(9);
        vectors++;
        if (state !== ST_IDLE || sel !== 2'd1 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_frozen got state=%b sel=%0d tick=%b, want state=00 sel=1 tick=0", state, sel, tick);
        end
        enable = 1;
        d      = cyc;
        push(2'd2, 1'b0, d + 1 + P);
        push(2'd3, 1'b0, d + 1 + 2 * P);
        clk(1 + 2 * P);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL reenable_ticks got %0d pending, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_step_in_auto();
        int e;
        e = cyc;
        push(2'd0, 1'b1, e + P);
        push(2'd1, 1'b0, e + 2 * P);
        clk(1);
        step = 1;
        clk(2);
        step = 0;
        clk(2 * P - 3);
        vectors++;
        if (sb.size() != 0 || sel !== 2'd1) begin
            miscompares++;
            $display("FAIL step_in_auto got pending=%0d sel=%0d, want pending=0 sel=1", sb.size(), sel);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_auto();
        int e;
        e = cyc;
        push(2'd2, 1'b0, e + P);
        clk(2 * P - 1);
        vectors++;
        if (sel !== 2'b10 || state !== ST_AUTO) begin
            miscompares++;
            $display("FAIL pre_reset got sel=%b state=%b, want sel=10 state=10", sel, state);
        end
        reset = 1;
        step  = 1;
        clk(1);
        vectors++;
        if (sel !== 2'b00 || tick !== 1'b0 || wrap !== 1'b0 || state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_mid_auto got sel=%b tick=%b wrap=%b state=%b, want sel=00 tick=0 wrap=0 state=00",
                     sel, tick, wrap, state);
        end
        reset = 0;
        push(2'd1, 1'b0, cyc + 1 + P);
        clk(1);
        step = 0;
        clk(P);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_ticks got %0d pending, want 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_auto();
        test_manual();
        test_step();
        test_enable_drop();
        test_step_in_auto();
        test_reset_mid_auto();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
